// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and constants for the pipeline hazard
//               controller: state encoding, default timeout and counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Controller states: normal flow, or parked behind a multi-cycle MDU op
    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MDU_WAIT = 1'b1
    } state_e;

    localparam int STATE_W         = 1;
    localparam int MDU_TMO_DEFAULT = 255;
    localparam int CNT_W_DEFAULT   = 32;

    // Width of a counter able to hold the value tmo (never below one bit)
    function automatic int wait_cnt_width(input int tmo);
        return (tmo < 2) ? 1 : $clog2(tmo + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_gnrl_dff.sv
`default_nettype none
// ============================================================================
// Module      : gnrl_dff
// Description : Generic register with synchronous active-high reset to a
//               parameterised value and an active-high hold (load disable).
// Revision    : 1.0 - initial release
// ============================================================================
module gnrl_dff #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hold,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Reset wins; otherwise load every cycle unless held
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Five-stage pipeline hazard controller. Resolves, in priority
//               order, data-bus stalls, multi-cycle MDU stalls, taken jumps
//               and load-use hazards into hold/flush/redirect controls, and
//               keeps stall/flush performance counters.
//               Build option: define PIPE_CTRL_MDU_EN to enable the MDU wait
//               state, its wait counter and the mdu_timeout abort pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MDU_TMO = MDU_TMO_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1_raddr,
    input  logic [4:0]       id_rs2_raddr,
    input  logic             id_rs1_ren,
    input  logic             id_rs2_ren,
    input  logic [4:0]       ex_rd_waddr,
    input  logic             ex_load,
    input  logic             ex_jump,
    input  logic [31:0]      ex_jump_addr,
    input  logic             mem_busy,
    input  logic             mdu_start,
    input  logic             mdu_done,
    output logic             hold_pc,
    output logic             hold_ifid,
    output logic             hold_idex,
    output logic             hold_exmem,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             pc_set,
    output logic [31:0]      pc_set_addr,
    output logic             mdu_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

`ifdef PIPE_CTRL_MDU_EN
    localparam bit c_mdu_en = 1'b1;
`else
    localparam bit c_mdu_en = 1'b0;
`endif

    localparam int                  c_wait_w   = wait_cnt_width(MDU_TMO);
    localparam logic [c_wait_w-1:0] c_wait_max = c_wait_w'(MDU_TMO);

    logic [STATE_W-1:0]  r_state_bits;
    state_e              r_state;
    state_e              w_state_d;
    logic [c_wait_w-1:0] r_wait_cnt;
    logic [c_wait_w-1:0] w_wait_d;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;
    logic [CNT_W-1:0]    w_stall_d;
    logic [CNT_W-1:0]    w_flush_d;
    logic                w_load_use;
    logic                w_mdu_stall;

    assign r_state = state_e'(r_state_bits);

    // Instruction in ID needs a register the load in EX has not produced yet
    assign w_load_use = ex_load && (ex_rd_waddr != 5'd0) &&
                        ((id_rs1_ren && (id_rs1_raddr == ex_rd_waddr)) ||
                         (id_rs2_ren && (id_rs2_raddr == ex_rd_waddr)));

    // Hazard resolution and next state, purely from state and current inputs
    always_comb begin
        hold_pc     = 1'b0;
        hold_ifid   = 1'b0;
        hold_idex   = 1'b0;
        hold_exmem  = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        pc_set      = 1'b0;
        pc_set_addr = 32'd0;
        mdu_timeout = 1'b0;
        w_mdu_stall = 1'b0;
        w_state_d   = r_state;
        w_wait_d    = r_wait_cnt;

        if (!rst) begin
            if (mem_busy) begin
                // Bus stall freezes everything, including the MDU wait count
                hold_pc    = 1'b1;
                hold_ifid  = 1'b1;
                hold_idex  = 1'b1;
                hold_exmem = 1'b1;
            end else begin
                if (c_mdu_en && (r_state == ST_RUN)) begin
                    if (mdu_start && !mdu_done) begin
                        w_mdu_stall = 1'b1;
                        w_state_d   = ST_MDU_WAIT;
                        w_wait_d    = '0;
                    end
                end else if (c_mdu_en && (r_state == ST_MDU_WAIT)) begin
                    if (mdu_done) begin
                        w_state_d = ST_RUN;
                        w_wait_d  = '0;
                    end else if (r_wait_cnt == c_wait_max) begin
                        // Give up on the unit: release the pipe and flag it
                        mdu_timeout = 1'b1;
                        w_state_d   = ST_RUN;
                        w_wait_d    = '0;
                    end else begin
                        w_mdu_stall = 1'b1;
                        w_wait_d    = r_wait_cnt + 1'b1;
                    end
                end

                if (w_mdu_stall) begin
                    hold_pc    = 1'b1;
                    hold_ifid  = 1'b1;
                    hold_idex  = 1'b1;
                    hold_exmem = 1'b1;
                end else if (ex_jump) begin
                    // Jump squashes any load-use bubble: the ID instruction dies
                    flush_ifid  = 1'b1;
                    flush_idex  = 1'b1;
                    pc_set      = 1'b1;
                    pc_set_addr = ex_jump_addr;
                end else if (w_load_use) begin
                    hold_pc    = 1'b1;
                    hold_ifid  = 1'b1;
                    flush_idex = 1'b1;
                end
            end
        end
    end

    // Performance counter increments, wrapping naturally at 2^CNT_W
    always_comb begin
        w_stall_d = r_stall_cnt + CNT_W'(hold_pc);
        w_flush_d = r_flush_cnt + CNT_W'(pc_set);
    end

    gnrl_dff #(
        .W       (STATE_W),
        .RST_VAL (STATE_W'(ST_RUN))
    ) u_state_dff (
        .clk  (clk),
        .rst  (rst),
        .hold (1'b0),
        .d    (STATE_W'(w_state_d)),
        .q    (r_state_bits)
    );

    gnrl_dff #(
        .W       (c_wait_w),
        .RST_VAL ('0)
    ) u_wait_dff (
        .clk  (clk),
        .rst  (rst),
        .hold (1'b0),
        .d    (w_wait_d),
        .q    (r_wait_cnt)
    );

    gnrl_dff #(
        .W       (CNT_W),
        .RST_VAL ('0)
    ) u_stall_dff (
        .clk  (clk),
        .rst  (rst),
        .hold (1'b0),
        .d    (w_stall_d),
        .q    (r_stall_cnt)
    );

    gnrl_dff #(
        .W       (CNT_W),
        .RST_VAL ('0)
    ) u_flush_dff (
        .clk  (clk),
        .rst  (rst),
        .hold (1'b0),
        .d    (w_flush_d),
        .q    (r_flush_cnt)
    );

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MDU_TMO, default 255, MDU_WAIT cycles before forced abort.
REQ-002 Parameter CNT_W, default 32, width of performance counters.
REQ-003 clk  in  1  single core clock, all state on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 id_rs1_raddr, id_rs2_raddr  in  5 each  source regs of instruction in ID.
REQ-006 id_rs1_ren, id_rs2_ren  in  1 each  source actually read.
REQ-007 ex_rd_waddr  in  5  destination of instruction in EX; ex_load  in  1  EX holds a load.
REQ-008 ex_jump  in  1  taken branch/jump resolved in EX; ex_jump_addr  in  32  target.
REQ-009 mem_busy  in  1  data bus not ready.
REQ-010 mdu_start  in  1  EX holds multi-cycle mul/div; mdu_done  in  1  result valid.
REQ-011 hold_pc, hold_ifid, hold_idex, hold_exmem  out  1 each  freeze PC / pipeline register.
REQ-012 flush_ifid, flush_idex  out  1 each  load bubble (NOP/default values) into register.
REQ-013 pc_set  out  1, pc_set_addr  out  32  redirect fetch.
REQ-014 mdu_timeout  out  1  one-cycle pulse on MDU abort.
REQ-015 stall_cnt, flush_cnt  out  CNT_W each  performance counters.

Function
REQ-016 States SHALL be RUN and MDU_WAIT; hazard outputs SHALL be combinational from state and inputs, zero latency.
REQ-017 Priority per cycle SHALL be: mem_busy > MDU stall > ex_jump > load-use > none.
REQ-018 mem_busy=1 SHALL assert all four holds, no flush, pc_set=0, state unchanged, MDU counter frozen.
REQ-019 RUN, mdu_start=1, mdu_done=0 SHALL assert all four holds and go to MDU_WAIT next cycle.
REQ-020 RUN, mdu_start=1, mdu_done=1 SHALL assert no hold and stay in RUN.
REQ-021 MDU_WAIT, mdu_done=0 SHALL assert all four holds and increment wait counter.
REQ-022 MDU_WAIT, mdu_done=1 SHALL release all holds that cycle and return to RUN; counter cleared.
REQ-023 Wait counter reaching MDU_TMO SHALL pulse mdu_timeout, release holds, return to RUN.
REQ-024 ex_jump=1 (not overridden) SHALL assert flush_ifid, flush_idex, pc_set, pc_set_addr=ex_jump_addr.
REQ-025 Load-use: ex_load=1, ex_rd_waddr!=0, and (rs1_ren and rs1==rd) or (rs2_ren and rs2==rd) SHALL assert hold_pc, hold_ifid, flush_idex for one cycle.
REQ-026 ex_jump with simultaneous load-use SHALL produce jump response only.
REQ-027 pc_set_addr SHALL be 0 whenever pc_set=0.
REQ-028 stall_cnt SHALL increment each cycle hold_pc=1; flush_cnt SHALL increment each cycle pc_set=1; both wrap at 2^CNT_W.

Reset
REQ-029 rst=1 SHALL force state RUN, wait counter 0, stall_cnt=flush_cnt=0, mdu_timeout=0, including mid-MDU_WAIT.
REQ-030 While rst=1 all holds, flushes, pc_set SHALL be 0 and pc_set_addr 0.

Configuration
REQ-031 With PIPE_CTRL_MDU_EN defined, MDU_WAIT logic, wait counter and mdu_timeout SHALL exist per REQ-019..023.
REQ-032 Without PIPE_CTRL_MDU_EN, mdu_start/mdu_done SHALL be ignored, state SHALL stay RUN, mdu_timeout tied 0; ports unchanged.

Structure
REQ-033 State encodings, MDU_TMO default and counter width SHALL live in defines.v.
REQ-034 State register, wait counter and perf counters SHALL use the shared gnrl_dff sub-module (hold tied 0).

Verification
REQ-035 ex_load=1, ex_rd=5, id_rs1=5, rs1_ren=1 -> hold_pc=hold_ifid=flush_idex=1 one cycle, stall_cnt +1.
REQ-036 Same with ex_rd=0 -> no hold, no flush.
REQ-037 ex_jump=1, addr=0x0000_0100 with load-use -> flush_ifid=flush_idex=pc_set=1, addr 0x100, no hold, flush_cnt +1.
REQ-038 mdu_start, mdu_done after 4 cycles -> holds high 4 cycles, low on done cycle, state RUN, stall_cnt +4.
REQ-039 mdu_start, no done -> mdu_timeout pulse after 255 wait cycles, holds drop; rst mid-wait -> all outputs 0 next cycle.
REQ-040 mem_busy=1 for 3 cycles during MDU_WAIT -> holds stay high, wait counter frozen, resumes afterwards.
